serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor; computes A - B - Bin, LSB first, one bit per clock.
- Uses a single full-subtractor cell with a registered borrow.
- Complements the team's combinational ripple adders: trades latency for area on wide operands.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  operand valid; accepted only when in_ready=1
A  input  WIDTH  minuend, sampled on accept
B  input  WIDTH  subtrahend, sampled on accept
Bin  input  1  borrow-in, sampled on accept
in_ready  output  1  block idle, can accept operands
Diff  output  WIDTH  result (A - B - Bin) mod 2^WIDTH
Bout  output  1  final borrow-out; 1 when A < B + Bin (unsigned)
Zero  output  1  Diff == 0
out_valid  output  1  Diff/Bout/Zero valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset (async assert, released on clock): state=IDLE, in_ready=1, out_valid=0, Diff=0, Bout=0, Zero=1, internal shift registers, borrow and bit counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with start=1: latch A, B into shift registers, load borrow <= Bin, counter <= 0, go to SHIFT.
- SHIFT (in_ready=0, out_valid=0), on each edge:
  - a0, b0 = current LSBs; br = registered borrow.
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the result register from the MSB side; shift the A and B registers right; counter++.
  - When counter reaches WIDTH-1 on that edge, the final bit is written and the state moves to DONE.
  - SHIFT lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1; Diff, Bout and Zero are stable and held.
  - On an edge with out_ready=1: go to IDLE, out_valid <= 0.
- Latency: the accept edge is edge 0 and out_valid rises after edge WIDTH. Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- Diff, Bout and Zero keep their last values after the handshake until the next result completes. They never show partial results: the result register is separate from the shift register and is updated only on the DONE transition.
- start while in SHIFT or DONE is ignored: no latch, no queuing.
- out_ready while not in DONE is ignored.
- In DONE with out_ready=1, in_ready is still 0 that cycle; a start is accepted no earlier than the following cycle.
- Wrap-around: A < B + Bin gives the two's-complement modular result with Bout=1.
  - Example (WIDTH=4): 0 - 0 - 1 = 4'hF, Bout=1.
- WIDTH=1: SHIFT lasts one cycle; the block behaves as a registered full subtractor.
- Reset mid-operation (any state): the operation is aborted immediately; outputs go to reset values and no result is produced.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port Ovf (1 bit).
  - Ovf = signed overflow of the two's-complement operation: A[MSB] != B[MSB] and Diff[MSB] != A[MSB].
  - Bin is treated as part of the subtrahend.
  - Ovf is registered alongside Diff, valid with out_valid, reset 0, and held like Diff.
- Undefined: the port does not exist and no overflow logic is generated.

Test Plan:
- WIDTH=4, A=4'b0111, B=4'b0010, Bin=0, out_ready=1 -> in_ready drops after accept; out_valid after 4 edges; Diff=4'b0101, Bout=0, Zero=0; back to IDLE one cycle later.
- A=4'b0011, B=4'b0101, Bin=0 -> Diff=4'b1110, Bout=1. Then A=0, B=0, Bin=1 -> Diff=4'b1111, Bout=1. Then A=4'b1010, B=4'b1010, Bin=0 -> Diff=0, Zero=1, Bout=0.
- Backpressure: complete A=9, B=3 with out_ready=0 for 10 cycles -> out_valid stays 1 and Diff=4'b0110 stays stable. Pulse start with A=1, B=1 during SHIFT and DONE -> ignored, result unchanged. Raise out_ready -> one handshake, then in_ready=1.
- Reset: assert rst asynchronously in the 2nd SHIFT cycle of A=15, B=1 -> Diff=0, Bout=0, Zero=1, out_valid=0, in_ready=1 immediately. A new op A=5, B=2 afterwards -> Diff=3.
- Back-to-back: out_ready=1 with start held high and changing operands each op -> each result matches its own operands; ops are spaced WIDTH+2 cycles apart.
- With SERIAL_SUB_OVF_EN:
  - A=4'b1000, B=4'b0001 -> Diff=4'b0111, Ovf=1.
  - A=4'b0111, B=4'b1111 -> Diff=4'b1000, Ovf=1.
  - A=4'b0101, B=4'b0011 -> Diff=4'b0010, Ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output Ovf.

module serial_subtractor_fs (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             in_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, res_next;
  logic [CW-1:0]    cnt;
  logic             br, d, br_next, last;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  serial_subtractor_fs u_fs (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (br),
    .d  (d),
    .bo (br_next)
  );

  // New bit enters from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_next = d;
    end else begin : g_wn
      assign res_next = {d, d_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last      = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
      Zero  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= A;
          b_sr  <= B;
          br    <= Bin;
          cnt   <= '0;
          state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb <= A[WIDTH-1];
          b_msb <= B[WIDTH-1];
`endif
        end
        SHIFT: begin
          d_sr <= res_next;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // Visible result only changes here, so consumers never see partial bits.
          if (last) begin
            Diff  <= res_next;
            Bout  <= br_next;
            Zero  <= ~|res_next;
`ifdef SERIAL_SUB_OVF_EN
            Ovf   <= (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
`endif
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepts push expected results, a negedge monitor pops and compares.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, bin, out_ready;
  logic [W-1:0] a, b, diff;
  logic         in_ready, bout, zero, out_valid;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (a),
    .B         (b),
    .Bin       (bin),
    .in_ready  (in_ready),
    .Diff      (diff),
    .Bout      (bout),
    .Zero      (zero),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           errors = 0, checks = 0, cyc = 0, last_acc = -1;
  logic         pv = 1'b0, b2b = 1'b0, rnd_or = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic         hold_bo = 1'b0, hold_z = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Plain integer arithmetic reference.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int due);
    exp_t m;
    int ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = ux - ((ux >= 2**(W-1)) ? 2**W : 0);
    sy = uy - ((uy >= 2**(W-1)) ? 2**W : 0);
    r  = ux - uy - int'(c);
    sr = sx - sy - int'(c);
    m.d   = W'(r);
    m.bo  = (ux < uy + int'(c));
    m.z   = (m.d == '0);
    m.ov  = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
    m.due = due;
    return m;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, expv, cyc);
    end
  endtask

  // Monitor: records accepts, checks latency, values while valid, and holding after handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (start && in_ready) begin
        if (b2b && last_acc >= 0) chk("spacing", 64'(cyc + 1 - last_acc), 64'(W + 2));
        last_acc = cyc + 1;
        q.push_back(model(a, b, bin, cyc + 1 + W));
      end
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 64'(out_valid), 64'(0));
        else begin
          if (!pv) chk("latency", 64'(cyc), 64'(q[0].due));
          chk("diff", 64'(diff), 64'(q[0].d));
          chk("bout", 64'(bout), 64'(q[0].bo));
          chk("zero", 64'(zero), 64'(q[0].z));
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", 64'(ovf), 64'(q[0].ov));
`endif
          if (out_ready) begin
            hold_d  = q[0].d;
            hold_bo = q[0].bo;
            hold_z  = q[0].z;
            void'(q.pop_front());
          end
        end
      end else begin
        chk("held_diff", 64'(diff), 64'(hold_d));
        chk("held_bout", 64'(bout), 64'(hold_bo));
        chk("held_zero", 64'(zero), 64'(hold_z));
      end
      pv = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int t = 0;
    while (!in_ready && t < 200) begin step(); t++; end
    if (t >= 200) chk("op_timeout", 64'(in_ready), 64'(1));
    start = 1'b1; a = x; b = y; bin = c;
    step();
    start = 1'b0; a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    rnd_or = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && t < 200) begin step(); t++; end
    if (t >= 200) chk("drain_timeout", 64'(q.size()), 64'(0));
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_diff", 64'(diff), 64'(0));
    chk("rst_bout", 64'(bout), 64'(0));
    chk("rst_zero", 64'(zero), 64'(1));
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'(0));
`endif
    @(posedge clk); #1; rst = 1'b0;
    step();

    // First op: in_ready drops right after accept, back to IDLE a cycle after result.
    op(4'b0111, 4'b0010, 1'b0);
    chk("in_ready_drop", 64'(in_ready), 64'(0));
    drain();
    chk("idle_after", 64'(in_ready), 64'(1));
    op(4'b0011, 4'b0101, 1'b0);
    op(4'b0000, 4'b0000, 1'b1);
    op(4'b1010, 4'b1010, 1'b0);
    op(4'b1000, 4'b0001, 1'b0);
    op(4'b0111, 4'b1111, 1'b0);
    op(4'b0101, 4'b0011, 1'b0);
    drain();

    // Backpressure with stray starts during SHIFT and DONE.
    out_ready = 1'b0;
    op(4'd9, 4'd3, 1'b0);
    start = 1'b1; a = 4'd1; b = 4'd1; step(); start = 1'b0;
    for (int t = 0; t < 20 && !out_valid; t++) step();
    start = 1'b1; a = 4'd1; b = 4'd1; step(); start = 1'b0;
    for (int t = 0; t < 10; t++) step();
    chk("bp_valid", 64'(out_valid), 64'(1));
    chk("bp_no_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    step();
    chk("bp_done_valid", 64'(out_valid), 64'(0));
    chk("bp_done_ready", 64'(in_ready), 64'(1));
    drain();

    // Asynchronous reset in the second SHIFT cycle.
    op(4'd15, 4'd1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    q.delete();
    hold_d = '0; hold_bo = 1'b0; hold_z = 1'b1; pv = 1'b0;
    chk("arst_diff", 64'(diff), 64'(0));
    chk("arst_bout", 64'(bout), 64'(0));
    chk("arst_zero", 64'(zero), 64'(1));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1; rst = 1'b0;
    step();
    op(4'd5, 4'd2, 1'b0);
    drain();

    // Back-to-back with start held high.
    b2b = 1'b1; last_acc = -1; out_ready = 1'b1;
    start = 1'b1; a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom_range(0, 1));
    for (int n = 0; n < 8; n++) begin
      for (int t = 0; t < 50 && !in_ready; t++) step();
      step();
      a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    drain();
    b2b = 1'b0;

    // Random operands with random backpressure.
    rnd_or = 1'b1;
    for (int n = 0; n < 40; n++)
      op(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)));
    drain();

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
